// File: rtl/msg_block_feeder_pkg.sv
// msg_block_feeder_pkg
//   Shared constants, FSM state type and the last-word byte-mask helper for the
//   BLAKE3 message block feeder and its block buffer.
package msg_block_feeder_pkg;

   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned BLOCK_BYTES = 64;
   localparam int unsigned CHUNK_BYTES = 1024;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_e;

   // Keeps the valid low-order bytes of the final message word. A remainder of
   // zero means the final word is completely filled.
   function automatic logic [31:0] last_word_mask(input logic [1:0] len_mod4);
      logic [31:0] mask;
      case (len_mod4)
         2'd0:    mask = 32'hFFFF_FFFF;
         2'd1:    mask = 32'h0000_00FF;
         2'd2:    mask = 32'h0000_FFFF;
         2'd3:    mask = 32'h00FF_FFFF;
         default: mask = 32'hFFFF_FFFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/msg_block_buffer.sv
// msg_block_buffer
//   16 x 32-bit block register feeding the hasher message bus directly.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     clr          : synchronous clear of all slots (wins over a write)
//     wr_en        : write wr_data & wr_mask into slot wr_idx
//     wr_idx       : destination slot
//     wr_data      : incoming message word
//     wr_mask      : byte mask applied to wr_data
//     blk_o        : registered block contents
module msg_block_buffer
   import msg_block_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [3:0]        wr_idx,
   input  logic [31:0]       wr_data,
   input  logic [31:0]       wr_mask,
   output logic [15:0][31:0] blk_o
);

   logic [15:0][31:0] blk_q;
   logic [15:0][31:0] blk_d;

   // Next block contents: clear, masked single-slot write, or hold.
   always_comb begin
      blk_d = blk_q;
      if (clr) begin
         blk_d = '0;
      end else if (wr_en) begin
         blk_d[wr_idx] = wr_data & wr_mask;
      end else begin
         blk_d = blk_q;
      end
   end

   // Block register.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_q <= '0;
      end else begin
         blk_q <= blk_d;
      end
   end

   assign blk_o = blk_q;

endmodule

// File: rtl/msg_block_feeder.sv
// msg_block_feeder
//   Packs a little-endian 32-bit word stream into zero-padded 64-byte blocks
//   for the BLAKE3 chunk hasher, one chunk (<= MAX_BYTES) per Start_I.
//   Ports:
//     Clk, Rst        : clock, synchronous active-high reset
//     Start_I, Len_I  : message start pulse and byte length (sampled in IDLE)
//     Data_I, Data_vld_I, Data_rdy_O : word stream handshake
//     Update_O, Msg_O, Byte_num_O    : block issue to the hasher
//     Hasher_addr_I, Hasher_vld_I    : hasher progress and final-hash valid
//     Busy_O, Done_O, Err_O          : status
//   MAX_BYTES must not exceed CHUNK_BYTES: word/block counts are derived from
//   Len_I[10:0] only.
module msg_block_feeder
   import msg_block_feeder_pkg::*;
#(
   parameter logic [31:0] MAX_BYTES = 32'd1024
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start_I,
   input  logic [31:0]       Len_I,
   input  logic [31:0]       Data_I,
   input  logic              Data_vld_I,
   output logic              Data_rdy_O,
   output logic              Update_O,
   output logic [15:0][31:0] Msg_O,
   output logic [31:0]       Byte_num_O,
   input  logic [9:0]        Hasher_addr_I,
   input  logic              Hasher_vld_I,
   output logic              Busy_O,
   output logic              Done_O,
   output logic              Err_O
);

   state_e      state_q, state_d;
   logic [31:0] len_q, len_d;
   logic [8:0]  words_q, words_d;
   logic [4:0]  blocks_q, blocks_d;
   logic [8:0]  word_cnt_q, word_cnt_d;
   logic [4:0]  blk_idx_q, blk_idx_d;
   logic [9:0]  addr_snap_q, addr_snap_d;
   logic        data_rdy_q, data_rdy_d;
   logic        update_q, update_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        xfer_s;
   logic        last_word_s;
   logic        block_full_s;
   logic [8:0]  len_words_s;
   logic [4:0]  len_blocks_s;
   logic        buf_clr_s;
   logic        buf_wr_s;
   logic [31:0] buf_mask_s;

   // ceil(Len/4) and ceil(Len/64) for Len <= 1024, without a wide adder.
   assign len_words_s  = Len_I[10:2] + {8'd0, |Len_I[1:0]};
   assign len_blocks_s = Len_I[10:6] + {4'd0, |Len_I[5:0]};

   assign xfer_s       = (state_q == ST_FILL) && Data_vld_I && data_rdy_q;
   assign last_word_s  = (word_cnt_q == (words_q - 9'd1));
   assign block_full_s = (word_cnt_q[3:0] == 4'(BLOCK_WORDS - 1));

   // FSM next state, counters, buffer control and next registered outputs.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      words_d     = words_q;
      blocks_d    = blocks_q;
      word_cnt_d  = word_cnt_q;
      blk_idx_d   = blk_idx_q;
      addr_snap_d = addr_snap_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      buf_clr_s   = 1'b0;
      buf_wr_s    = 1'b0;
      buf_mask_s  = 32'hFFFF_FFFF;

      case (state_q)
         ST_IDLE: begin
            if (Start_I) begin
               if (Len_I > MAX_BYTES) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  len_d      = Len_I;
                  words_d    = len_words_s;
                  // An empty message still hashes one all-zero block.
                  blocks_d   = (len_blocks_s == 5'd0) ? 5'd1 : len_blocks_s;
                  word_cnt_d = 9'd0;
                  blk_idx_d  = 5'd0;
                  buf_clr_s  = 1'b1;
                  state_d    = ST_FILL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (xfer_s) begin
               buf_wr_s   = 1'b1;
               buf_mask_s = last_word_s ? last_word_mask(len_q[1:0]) : 32'hFFFF_FFFF;
               word_cnt_d = word_cnt_q + 9'd1;
               if (last_word_s || block_full_s) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_FILL;
               end
            end else if (word_cnt_q >= words_q) begin
               // Only reachable for Len = 0: nothing to collect.
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_ISSUE: begin
            addr_snap_d = Hasher_addr_I;
            if (blk_idx_q == (blocks_q - 5'd1)) begin
               state_d = ST_WAIT_DONE;
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // Any address movement means the hasher has consumed Msg_O.
            if (Hasher_addr_I != addr_snap_q) begin
               buf_clr_s = 1'b1;
               blk_idx_d = blk_idx_q + 5'd1;
               state_d   = ST_FILL;
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_DONE: begin
            if (Hasher_vld_I) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      update_d   = (state_d == ST_ISSUE);
      busy_d     = (state_d != ST_IDLE);
      data_rdy_d = (state_d == ST_FILL) && (word_cnt_d < words_d);
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         len_q       <= 32'd0;
         words_q     <= 9'd0;
         blocks_q    <= 5'd0;
         word_cnt_q  <= 9'd0;
         blk_idx_q   <= 5'd0;
         addr_snap_q <= 10'd0;
         data_rdy_q  <= 1'b0;
         update_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         words_q     <= words_d;
         blocks_q    <= blocks_d;
         word_cnt_q  <= word_cnt_d;
         blk_idx_q   <= blk_idx_d;
         addr_snap_q <= addr_snap_d;
         data_rdy_q  <= data_rdy_d;
         update_q    <= update_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   msg_block_buffer u_buf (
      .clk     (Clk),
      .rst     (Rst),
      .clr     (buf_clr_s),
      .wr_en   (buf_wr_s),
      .wr_idx  (word_cnt_q[3:0]),
      .wr_data (Data_I),
      .wr_mask (buf_mask_s),
      .blk_o   (Msg_O)
   );

   assign Data_rdy_O = data_rdy_q;
   assign Update_O   = update_q;
   assign Byte_num_O = len_q;
   assign Busy_O     = busy_q;
   assign Done_O     = done_q;
   assign Err_O      = err_q;

endmodule

// File: tb/tb_msg_block_feeder.sv
// Scoreboard bench for msg_block_feeder: stimulus pushes expected blocks,
// a negedge monitor compares them on every Update_O; a small hasher model
// moves Addr_O and pulses Vld_O a few cycles after each issued block.
module tb_msg_block_feeder;

   typedef logic [15:0][31:0] blk_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start_I = 1'b0;
   logic [31:0] Len_I = 32'd0;
   logic [31:0] Data_I = 32'd0;
   logic        Data_vld_I = 1'b0;
   logic        Data_rdy_O;
   logic        Update_O;
   blk_t        Msg_O;
   logic [31:0] Byte_num_O;
   logic [9:0]  Hasher_addr_I = 10'd0;
   logic        Hasher_vld_I = 1'b0;
   logic        Busy_O;
   logic        Done_O;
   logic        Err_O;

   blk_t        exp_q[$];
   logic [31:0] exp_len_q[$];
   blk_t        mon_blk;
   logic [31:0] mon_len;
   int total = 0;
   int bad = 0;
   int upd_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int ack_dly = 0;

   always #5 Clk = ~Clk;

   msg_block_feeder dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Start_I       (Start_I),
      .Len_I         (Len_I),
      .Data_I        (Data_I),
      .Data_vld_I    (Data_vld_I),
      .Data_rdy_O    (Data_rdy_O),
      .Update_O      (Update_O),
      .Msg_O         (Msg_O),
      .Byte_num_O    (Byte_num_O),
      .Hasher_addr_I (Hasher_addr_I),
      .Hasher_vld_I  (Hasher_vld_I),
      .Busy_O        (Busy_O),
      .Done_O        (Done_O),
      .Err_O         (Err_O)
   );

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compare each issued block against the queue head.
   always @(negedge Clk) begin
      if (Update_O) begin
         upd_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: got Update_O=1 expected no block");
         end else begin
            mon_blk = exp_q.pop_front();
            mon_len = exp_len_q.pop_front();
            check("msg_block", Msg_O, mon_blk);
            check("byte_num", Byte_num_O, mon_len);
         end
      end
      if (Done_O) done_cnt++;
      if (Err_O) err_cnt++;
      if (Err_O || Done_O) check("err_done_exclusive", Err_O & Done_O, 1'b0);
   end

   // Hasher model: address moves (and Vld_O pulses) 3 cycles after Update_O.
   always @(negedge Clk) begin
      Hasher_vld_I = 1'b0;
      if (Rst) begin
         ack_dly = 0;
      end else if (Update_O) begin
         ack_dly = 3;
      end else if (ack_dly != 0) begin
         check("rdy_low_until_ack", Data_rdy_O, 1'b0);
         ack_dly--;
         if (ack_dly == 0) begin
            Hasher_addr_I = Hasher_addr_I + 10'd64;
            Hasher_vld_I  = 1'b1;
         end
      end
   end

   task automatic push_exp(input blk_t b, input logic [31:0] len);
      exp_q.push_back(b);
      exp_len_q.push_back(len);
   endtask

   task automatic start_msg(input logic [31:0] len);
      @(negedge Clk);
      Start_I = 1'b1;
      Len_I   = len;
      @(negedge Clk);
      Start_I = 1'b0;
      check("busy_t1", Busy_O, len <= 32'd1024);
      check("rdy_t1", Data_rdy_O, (len != 32'd0) && (len <= 32'd1024));
      check("err_t1", Err_O, len > 32'd1024);
      if (len <= 32'd1024) check("byte_num_t1", Byte_num_O, len);
   endtask

   task automatic send_word(input logic [31:0] w);
      Data_I     = w;
      Data_vld_I = 1'b1;
      for (int i = 0; i < 100 && !Data_rdy_O; i++) @(negedge Clk);
      if (!Data_rdy_O) begin
         total++;
         bad++;
         $display("FAIL rdy_timeout: got Data_rdy_O=0 expected 1 within 100 cycles");
      end
      @(negedge Clk);
      Data_vld_I = 1'b0;
   endtask

   task automatic wait_done(input int exp_done);
      for (int i = 0; i < 300 && done_cnt < exp_done; i++) @(posedge Clk);
      @(posedge Clk);
      check("done_count", done_cnt, exp_done);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"}, Data_rdy_O, 1'b0);
      check({tag, "_update"}, Update_O, 1'b0);
      check({tag, "_busy"}, Busy_O, 1'b0);
      check({tag, "_done"}, Done_O, 1'b0);
      check({tag, "_err"}, Err_O, 1'b0);
      check({tag, "_msg"}, Msg_O, '0);
      check({tag, "_byte_num"}, Byte_num_O, 32'd0);
   endtask

   initial begin
      blk_t b;
      int   u0;
      int   e0;

      // Reset state
      repeat (2) @(negedge Clk);
      check_reset_outputs("reset");
      Rst = 1'b0;

      // Len = 64: one full block, Msg_O[i] = i
      b = '0;
      for (int i = 0; i < 16; i++) b[i] = 32'(i);
      push_exp(b, 32'd64);
      u0 = upd_cnt;
      start_msg(32'd64);
      for (int i = 0; i < 16; i++) send_word(32'(i));
      check("update_after_last_word", Update_O, 1'b1);
      wait_done(1);
      check("len64_updates", upd_cnt - u0, 1);

      // Len = 6: tail masked to 2 bytes
      b = '0;
      b[0] = 32'h4433_2211;
      b[1] = 32'h0000_6655;
      push_exp(b, 32'd6);
      start_msg(32'd6);
      send_word(32'h4433_2211);
      send_word(32'h8877_6655);
      wait_done(2);

      // Len = 0: single zero block, no data accepted
      push_exp('0, 32'd0);
      u0 = upd_cnt;
      start_msg(32'd0);
      check("len0_rdy_t2", Data_rdy_O, 1'b0);
      @(negedge Clk);
      check("len0_update_t2", Update_O, 1'b1);
      wait_done(3);
      check("len0_updates", upd_cnt - u0, 1);

      // Len = 70: full block then 2-word block with masked tail
      b = '0;
      for (int i = 0; i < 16; i++) b[i] = 32'hC0DE_0000 + 32'(i);
      push_exp(b, 32'd70);
      b = '0;
      b[0] = 32'hC0DE_0010;
      b[1] = 32'h0000_0011;
      push_exp(b, 32'd70);
      u0 = upd_cnt;
      start_msg(32'd70);
      for (int k = 0; k < 18; k++) send_word(32'hC0DE_0000 + 32'(k));
      wait_done(4);
      check("len70_updates", upd_cnt - u0, 2);

      // Len = 1025: rejected
      u0 = upd_cnt;
      e0 = err_cnt;
      start_msg(32'd1025);
      repeat (5) @(negedge Clk);
      check("err_count", err_cnt - e0, 1);
      check("err_busy", Busy_O, 1'b0);
      check("err_no_update", upd_cnt - u0, 0);

      // Len = 1024: 16 blocks, each paced by the hasher address
      for (int blk = 0; blk < 16; blk++) begin
         b = '0;
         for (int i = 0; i < 16; i++) b[i] = {16'hB1A3, 16'(blk * 16 + i)};
         push_exp(b, 32'd1024);
      end
      u0 = upd_cnt;
      start_msg(32'd1024);
      for (int k = 0; k < 256; k++) send_word({16'hB1A3, 16'(k)});
      wait_done(5);
      check("len1024_updates", upd_cnt - u0, 16);

      // Reset mid-FILL after 7 words, then Len = 4
      start_msg(32'd40);
      for (int k = 0; k < 7; k++) send_word(32'h5555_0000 + 32'(k));
      Rst = 1'b1;
      @(negedge Clk);
      check_reset_outputs("midrst");
      Rst = 1'b0;
      b = '0;
      b[0] = 32'hDEAD_BEEF;
      push_exp(b, 32'd4);
      start_msg(32'd4);
      send_word(32'hDEAD_BEEF);
      wait_done(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
